// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and elaboration helpers for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    typedef enum logic {OWN_IF, OWN_D} owner_e;

    // Both the read latency and the starvation limit must be at least one.
    function automatic bit params_ok(input int lat, input int starve);
        return (lat >= 1) && (starve >= 1);
    endfunction

    // Width of a down-counter that must hold n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// master: pipeline + memory side, slave: the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          d_stall;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_rvalid, if_rdata, if_stall, d_done, d_rdata, d_stall,
               m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_rvalid, if_rdata, if_stall, d_done, d_rdata, d_stall,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants made while a fetch was waiting.
// Clear wins over increment; sat_o tells the arbiter to let fetch through.
module starve_ctr #(
    parameter int STARVE = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);
    localparam int CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] SAT = CW'(STARVE);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear, else count up until saturation
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == SAT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM stage accesses onto one single-ported memory.
// Data has priority; a fetch is forced through after STARVE data grants.
// One access takes LAT+3 cycles: IDLE, ISSUE, LAT WAIT cycles, DONE.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mem_port_arbiter_if.slave    bus
);
    localparam int CW = cnt_w(LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    if (!params_ok(LAT, STARVE)) begin : g_bad_params
        $error("mem_port_arbiter: LAT and STARVE must both be >= 1");
    end

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          own_we_q, own_we_d;
    logic          abandon_q, abandon_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          m_en_q, m_en_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          d_done_q, d_done_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic if_qual, d_qual, grant_d, grant_if;
    logic starve_inc, starve_clr, starve_sat;
    logic fetch_dropped;

    // A request whose completion pulse is showing this cycle is already served.
    assign if_qual  = bus.if_req & ~if_rvalid_q;
    assign d_qual   = bus.d_req & ~d_done_q;
    assign grant_d  = (state_q == IDLE) & d_qual & ~(if_qual & starve_sat);
    assign grant_if = (state_q == IDLE) & if_qual & ~grant_d;

    assign starve_inc = grant_d & bus.if_req;
    assign starve_clr = grant_if | ~bus.if_req;

    // Branch flush: fetch owner withdrew its request mid-access.
    assign fetch_dropped = (owner_q == OWN_IF) & ~bus.if_req;

    starve_ctr #(.STARVE(STARVE)) u_starve (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    // Next-state, grant capture and completion pulses
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        own_we_d    = own_we_q;
        abandon_d   = abandon_q;
        cnt_d       = cnt_q;
        m_en_d      = 1'b0;
        m_we_d      = 1'b0;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_done_d    = 1'b0;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_d || grant_if) begin
                    state_d   = ISSUE;
                    abandon_d = 1'b0;
                    m_en_d    = 1'b1;
                    if (grant_d) begin
                        owner_d   = OWN_D;
                        own_we_d  = bus.d_we;
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        owner_d  = OWN_IF;
                        own_we_d = 1'b0;
                        m_addr_d = bus.if_addr;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
                if (fetch_dropped) abandon_d = 1'b1;
            end
            WAIT: begin
                if (fetch_dropped) abandon_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (owner_q == OWN_D) begin
                        d_done_d = 1'b1;
                        if (!own_we_q) d_rdata_d = bus.m_rdata;
                    end else if (!abandon_q && bus.if_req) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = bus.m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, owner and latency counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            own_we_q  <= 1'b0;
            abandon_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            own_we_q  <= own_we_d;
            abandon_q <= abandon_d;
            cnt_q     <= cnt_d;
        end
    end

    // Registered memory strobe/bus and requester return data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_en_q      <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            m_en_q      <= m_en_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.m_en      = m_en_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_rvalid_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;
endmodule
